bf16_op_issuer: RTL and testbench

- Sequential front end that drives the operand side of the bfloat16 operation mux and collects its result.
- Accepts one operation request per valid/ready handshake and registers the opcode and both operands.
- Holds them on the mux for a fixed settle latency, then captures the 16-bit result and overflow flag into a response register.
- Presents the response with valid/ready backpressure; it sits between the core's command path and the add/sub/mul/div datapath.

---
 rtl/data_type_pkg.sv | 32 +++
 rtl/op_intf.sv | 37 +++
 rtl/sat_counter.sv | 37 +++
 rtl/bf16_op_issuer.sv | 191 +++++++++++++++++++
 tb/tb_bf16_op_issuer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_type_pkg.sv
// -----------------------------------------------------------------------------
// data_type_pkg
// Shared types for the bfloat16 datapath:
//   - OP_* opcode constants understood by the add/sub/mul/div operation mux
//   - issuer_state_e : state encoding of the bf16_op_issuer front end
//   - bf16_t         : bfloat16 word {sign, exp[7:0], frac[6:0]}
//   - is_legal_op()  : true for the four opcodes the mux implements
// -----------------------------------------------------------------------------
package data_type_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } issuer_state_e;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage : data_type_pkg

// File: rtl/op_intf.sv
// -----------------------------------------------------------------------------
// op_intf
// Operand/result bundle between a command front end and the bf16 operation mux.
//   op1_*, op2_*    : operands, {sign, exp, frac} split into fields
//   op3_*, overflow : result of the selected operation
// Modports:
//   bus_side : front end, drives the operands and reads the result
//   mux_side : datapath, reads the operands and drives the result
// -----------------------------------------------------------------------------
interface op_intf;

  logic       op1_sign;
  logic [7:0] op1_exp;
  logic [6:0] op1_frac;
  logic       op2_sign;
  logic [7:0] op2_exp;
  logic [6:0] op2_frac;
  logic       op3_sign;
  logic [7:0] op3_exp;
  logic [6:0] op3_frac;
  logic       overflow;

  modport bus_side (
    output op1_sign, op1_exp, op1_frac,
    output op2_sign, op2_exp, op2_frac,
    input  op3_sign, op3_exp, op3_frac,
    input  overflow
  );

  modport mux_side (
    input  op1_sign, op1_exp, op1_frac,
    input  op2_sign, op2_exp, op2_frac,
    output op3_sign, op3_exp, op3_frac,
    output overflow
  );

endinterface : op_intf

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones instead of wrapping.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, clears the count
//   inc_i  : add one this cycle (ignored once saturated)
//   cnt_o  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/bf16_op_issuer.sv
// -----------------------------------------------------------------------------
// bf16_op_issuer
// Sequential front end of the bf16 add/sub/mul/div datapath. Accepts one
// request per valid/ready handshake, holds the operands on the operation mux
// for LATENCY cycles, captures the result and presents it as a response with
// valid/ready backpressure. Every output comes straight from a flop.
//
// Parameters:
//   LATENCY        : cycles the operands are held on the mux (>= 1)
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   req_valid_i    : request valid          req_ready_o : request ready
//   req_op_i       : opcode (OP_* codes)    req_op1_i/req_op2_i : bf16 operands
//   op_o           : opcode driven to the mux (keeps the last accepted opcode)
//   mux_intf       : operands out (zero outside WAIT), result/overflow in
//   rsp_valid_o    : response valid         rsp_ready_i : response ready
//   rsp_result_o   : captured result        rsp_overflow_o : captured overflow
//   rsp_illegal_o  : request carried an opcode the mux does not implement
//   ovf_cnt_o      : saturating count of overflowing responses, present only
//                    when BF16_OP_ISSUER_OVF_CNT_EN is defined
// -----------------------------------------------------------------------------
module bf16_op_issuer
  import data_type_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [15:0] req_op1_i,
  input  logic [15:0] req_op2_i,
  output logic [3:0]  op_o,
  op_intf.bus_side    mux_intf,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_result_o,
  output logic        rsp_overflow_o,
  output logic        rsp_illegal_o
`ifdef BF16_OP_ISSUER_OVF_CNT_EN
  ,
  output logic [15:0] ovf_cnt_o
`endif
);

  if (LATENCY < 1) begin : g_bad_latency
    $error("bf16_op_issuer: LATENCY must be at least 1");
  end

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  issuer_state_e    state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             req_ready_d, req_ready_q;
  logic [3:0]       op_d, op_q;
  bf16_t            op1_d, op1_q;
  bf16_t            op2_d, op2_q;
  logic             rsp_valid_d, rsp_valid_q;
  bf16_t            rsp_result_d, rsp_result_q;
  logic             rsp_overflow_d, rsp_overflow_q;
  logic             rsp_illegal_d, rsp_illegal_q;
  bf16_t            mux_result;

  assign mux_result = {mux_intf.op3_sign, mux_intf.op3_exp, mux_intf.op3_frac};

  // The operand registers double as the mux drive: they are loaded only for a
  // legal request and cleared when WAIT ends, so the mux sees zeros otherwise.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; without that, synthesis infers a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_ready_d    = req_ready_q;
    op_d           = op_q;
    op1_d          = op1_q;
    op2_d          = op2_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_illegal_d  = rsp_illegal_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d        = req_op_i;
          req_ready_d = 1'b0;
          if (is_legal_op(req_op_i)) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
            op1_d   = req_op1_i;
            op2_d   = req_op2_i;
          end else begin
            // Nothing to compute: answer immediately with a flagged zero.
            state_d        = RESP;
            rsp_valid_d    = 1'b1;
            rsp_result_d   = '0;
            rsp_overflow_d = 1'b0;
            rsp_illegal_d  = 1'b1;
          end
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          state_d        = RESP;
          rsp_valid_d    = 1'b1;
          rsp_result_d   = mux_result;
          rsp_overflow_d = mux_intf.overflow;
          rsp_illegal_d  = 1'b0;
          op1_d          = '0;
          op2_d          = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      req_ready_q    <= 1'b1;
      op_q           <= 4'h0;
      op1_q          <= '0;
      op2_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_illegal_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      op_q           <= op_d;
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_illegal_q  <= rsp_illegal_d;
    end
  end

  assign req_ready_o       = req_ready_q;
  assign op_o              = op_q;
  assign mux_intf.op1_sign = op1_q.sign;
  assign mux_intf.op1_exp  = op1_q.exp;
  assign mux_intf.op1_frac = op1_q.frac;
  assign mux_intf.op2_sign = op2_q.sign;
  assign mux_intf.op2_exp  = op2_q.exp;
  assign mux_intf.op2_frac = op2_q.frac;
  assign rsp_valid_o       = rsp_valid_q;
  assign rsp_result_o      = rsp_result_q;
  assign rsp_overflow_o    = rsp_overflow_q;
  assign rsp_illegal_o     = rsp_illegal_q;

`ifdef BF16_OP_ISSUER_OVF_CNT_EN
  logic ovf_inc;

  // Count at the response handshake so a held response is counted once.
  assign ovf_inc = (state_q == RESP) && rsp_ready_i && rsp_overflow_q;

  sat_counter #(
    .W (16)
  ) u_ovf_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (ovf_inc),
    .cnt_o  (ovf_cnt_o)
  );
`else
  // Overflow counter not built.
`endif

endmodule : bf16_op_issuer

// File: tb/tb_bf16_op_issuer.sv
// -----------------------------------------------------------------------------
// tb_bf16_op_issuer
// Drives three issuers (LATENCY = 1, 3, 4) that share clock and reset. Each
// one is attached to a stand-in operation mux that returns known bf16 results
// for the directed vectors and a fixed scramble of the operands otherwise.
// Expected responses are queued when a request is accepted and compared when
// the issuer raises rsp_valid_o.
// -----------------------------------------------------------------------------
module tb_bf16_op_issuer;
  import data_type_pkg::*;

  localparam int N = 3;

  typedef struct {
    int          inst;
    logic [15:0] result;
    logic        ovf;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid   [N];
  logic        req_ready   [N];
  logic [3:0]  req_op      [N];
  logic [15:0] req_op1     [N];
  logic [15:0] req_op2     [N];
  logic [3:0]  op_w        [N];
  logic        rsp_valid   [N];
  logic        rsp_ready   [N];
  logic [15:0] rsp_result  [N];
  logic        rsp_overflow[N];
  logic        rsp_illegal [N];
  logic [15:0] ovf_cnt     [N];
  logic [15:0] mux_a       [N];
  logic [15:0] mux_b       [N];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  op_intf mux_if[N] ();

  // Stand-in datapath: {overflow, result}.
  function automatic logic [16:0] mux_model(input logic [3:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
    if (op == OP_ADD && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
    if (op == OP_SUB && a == 16'h4040 && b == 16'h3F80) return {1'b0, 16'h4000};
    if (op == OP_MUL && a == 16'h7F00 && b == 16'h7F00) return {1'b1, 16'h7F80};
    if (op == OP_DIV && a == 16'h4000 && b == 16'h3F80) return {1'b0, 16'h4000};
    return {1'b0, a ^ {b[7:0], b[15:8]} ^ {12'h0, op}};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [16:0] mux_out;

    bf16_op_issuer #(
      .LATENCY ((g == 0) ? 1 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_valid_i    (req_valid[g]),
      .req_ready_o    (req_ready[g]),
      .req_op_i       (req_op[g]),
      .req_op1_i      (req_op1[g]),
      .req_op2_i      (req_op2[g]),
      .op_o           (op_w[g]),
      .mux_intf       (mux_if[g]),
      .rsp_valid_o    (rsp_valid[g]),
      .rsp_ready_i    (rsp_ready[g]),
      .rsp_result_o   (rsp_result[g]),
      .rsp_overflow_o (rsp_overflow[g]),
      .rsp_illegal_o  (rsp_illegal[g])
`ifdef BF16_OP_ISSUER_OVF_CNT_EN
      ,
      .ovf_cnt_o      (ovf_cnt[g])
`endif
    );

    assign mux_a[g] = {mux_if[g].op1_sign, mux_if[g].op1_exp, mux_if[g].op1_frac};
    assign mux_b[g] = {mux_if[g].op2_sign, mux_if[g].op2_exp, mux_if[g].op2_frac};
    assign mux_out  = mux_model(op_w[g], mux_a[g], mux_b[g]);
    assign mux_if[g].overflow = mux_out[16];
    assign mux_if[g].op3_sign = mux_out[15];
    assign mux_if[g].op3_exp  = mux_out[14:7];
    assign mux_if[g].op3_frac = mux_out[6:0];
  end

`ifndef BF16_OP_ISSUER_OVF_CNT_EN
  initial for (int i = 0; i < N; i++) ovf_cnt[i] = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, hold it until accepted, and queue its expectation.
  task automatic issue(input int i, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic push);
    logic [16:0] m;
    int          n;
    req_op[i]    = op;
    req_op1[i]   = a;
    req_op2[i]   = b;
    req_valid[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 20) begin
      tick();
      n++;
    end
    check("req_ready_before_accept", 32'(req_ready[i]), 32'd1);
    if (push) begin
      m = mux_model(op, a, b);
      if (is_legal_op(op)) sb.push_back('{i, m[15:0], m[16], 1'b0});
      else                 sb.push_back('{i, 16'h0, 1'b0, 1'b1});
    end
    tick();
    req_valid[i] = 1'b0;
    check("req_ready_after_accept", 32'(req_ready[i]), 32'd0);
  endtask

  // Called in cycle 1 after acceptance; checks response latency and content.
  task automatic wait_rsp(input int i, input int exp_lat);
    exp_t e;
    int   n;
    n = 1;
    while (!rsp_valid[i] && n < 20) begin
      tick();
      n++;
    end
    check("rsp_latency", 32'(n), 32'(exp_lat));
    check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
    if (rsp_valid[i] && sb.size() != 0) begin
      e = sb.pop_front();
      check("rsp_inst", 32'(e.inst), 32'(i));
      check("rsp_result", 32'(rsp_result[i]), 32'(e.result));
      check("rsp_overflow", 32'(rsp_overflow[i]), 32'(e.ovf));
      check("rsp_illegal", 32'(rsp_illegal[i]), 32'(e.illegal));
    end
  endtask

  initial begin
    int          seen;
    logic [3:0]  rop;
    logic [15:0] ra, rb;

    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_op[i]    = 4'h0;
      req_op1[i]   = 16'h0;
      req_op2[i]   = 16'h0;
      rsp_ready[i] = 1'b1;
    end
    #12;

    // Reset values.
    for (int i = 0; i < N; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_op", 32'(op_w[i]), 32'd0);
      check("rst_result", 32'(rsp_result[i]), 32'd0);
      check("rst_mux_a", 32'(mux_a[i]), 32'd0);
    end
`ifdef BF16_OP_ISSUER_OVF_CNT_EN
    check("rst_ovf_cnt", 32'(ovf_cnt[0]), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Happy path, LATENCY=1: ADD 1.0 + 2.0.
    issue(0, OP_ADD, 16'h3F80, 16'h4000, 1'b1);
    check("add_mux_a", 32'(mux_a[0]), 32'h3F80);
    check("add_mux_b", 32'(mux_b[0]), 32'h4000);
    check("add_op", 32'(op_w[0]), 32'(OP_ADD));
    wait_rsp(0, 2);
    check("add_mux_a_after", 32'(mux_a[0]), 32'd0);
    tick();
    check("add_rsp_valid_clr", 32'(rsp_valid[0]), 32'd0);
    check("add_req_ready_back", 32'(req_ready[0]), 32'd1);

    // Overflow: MUL large x large.
    issue(0, OP_MUL, 16'h7F00, 16'h7F00, 1'b1);
    wait_rsp(0, 2);
`ifdef BF16_OP_ISSUER_OVF_CNT_EN
    check("ovf_cnt_before", 32'(ovf_cnt[0]), 32'd0);
`endif
    tick();
`ifdef BF16_OP_ISSUER_OVF_CNT_EN
    check("ovf_cnt_after", 32'(ovf_cnt[0]), 32'd1);
`endif
    check("mul_req_ready_back", 32'(req_ready[0]), 32'd1);

    // Backpressure, LATENCY=3: SUB 3.0 - 1.0 held for 5 cycles.
    rsp_ready[1] = 1'b0;
    issue(1, OP_SUB, 16'h4040, 16'h3F80, 1'b1);
    wait_rsp(1, 4);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid_held", 32'(rsp_valid[1]), 32'd1);
      check("bp_result_held", 32'(rsp_result[1]), 32'h4000);
      check("bp_req_ready_low", 32'(req_ready[1]), 32'd0);
      tick();
    end
    rsp_ready[1] = 1'b1;
    check("bp_req_ready_at_hs", 32'(req_ready[1]), 32'd0);
    tick();
    check("bp_valid_clr", 32'(rsp_valid[1]), 32'd0);
    check("bp_req_ready_back", 32'(req_ready[1]), 32'd1);

    // Illegal opcode: immediate flagged response, operands never reach the mux.
    rsp_ready[1] = 1'b0;
    issue(1, 4'hF, 16'h1234, 16'h5678, 1'b1);
    check("ill_mux_a", 32'(mux_a[1]), 32'd0);
    check("ill_mux_b", 32'(mux_b[1]), 32'd0);
    wait_rsp(1, 1);
    rsp_ready[1] = 1'b1;
    tick();
    check("ill_req_ready_back", 32'(req_ready[1]), 32'd1);
    check("ill_op_kept", 32'(op_w[1]), 32'hF);

    // Back-to-back random legal ops, LATENCY=4: ready returns in cycle L+2.
    for (int k = 0; k < 4; k++) begin
      rop = 4'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      issue(2, rop, ra, rb, 1'b1);
      check("rnd_mux_a", 32'(mux_a[2]), 32'(ra));
      wait_rsp(2, lat_of(2) + 1);
      tick();
      check("rnd_req_ready_back", 32'(req_ready[2]), 32'd1);
    end

    // Reset in the middle of WAIT: operation dropped, no response.
    issue(2, OP_DIV, 16'h4000, 16'h3F80, 1'b0);
    tick();
    check("rstmid_in_wait", 32'(mux_a[2]), 32'h4000);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_req_ready", 32'(req_ready[2]), 32'd1);
    check("rstmid_rsp_valid", 32'(rsp_valid[2]), 32'd0);
    check("rstmid_op", 32'(op_w[2]), 32'd0);
    check("rstmid_mux_a", 32'(mux_a[2]), 32'd0);
    check("rstmid_mux_b", 32'(mux_b[2]), 32'd0);
    #2 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rsp_valid[2]) seen++;
    end
    check("rstmid_no_response", 32'(seen), 32'd0);
    check("rstmid_req_ready_after", 32'(req_ready[2]), 32'd1);

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bf16_op_issuer
